// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package counter_pkg;

   // Count direction as seen on the 'up' input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Behaviour at the count bounds, selected by the SATURATE parameter.
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Clamp a requested load value into the legal range 0..top.
   // Operands are 64 bits wide, which covers every practical counter width.
   function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                              input logic [63:0] top);
      return (value > top) ? top : value;
   endfunction

endpackage

// File: rtl/mod_next_state.sv
// Combinational next-count, wrap and terminal-count logic for one counter digit.
// Any count at or above MODULUS-1 is treated as sitting at the top bound.
module mod_next_state
   import counter_pkg::*;
#(
   parameter int WIDTH    = 6,
   parameter int MODULUS  = 64,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count_next,
   output logic             wrap_next,
   output logic             tc
);

   // MODULUS-1 held as a WIDTH-bit constant; all ones when MODULUS == 2**WIDTH.
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

   logic             at_top;
   logic             at_bottom;
   logic [WIDTH-1:0] eff_count;

   assign at_top    = (count >= TOP);
   assign at_bottom = (count == '0);
   assign eff_count = at_top ? TOP : count;

   assign tc = enable & ((up == DIR_UP) ? at_top : at_bottom);

   // Priority load > enable > hold; wrap only when a bound is crossed.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      count_next = count;
      wrap_next  = 1'b0;
      if (load) begin
         count_next = WIDTH'(clamp_load(64'(load_value), 64'(TOP)));
      end else if (enable) begin
         if (up == DIR_UP) begin
            if (!at_top) begin
               count_next = count + WIDTH'(1);
            end else if (SATURATE == MODE_SAT) begin
               count_next = TOP;
            end else begin
               count_next = '0;
               wrap_next  = 1'b1;
            end
         end else begin
            if (!at_bottom) begin
               count_next = eff_count - WIDTH'(1);
            end else if (SATURATE == MODE_SAT) begin
               count_next = '0;
            end else begin
               count_next = TOP;
               wrap_next  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter: state registers and asynchronous clear around
// the mod_next_state logic. Cascade digits by feeding tc into the next enable.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 6,
   parameter int MODULUS  = 64,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] count_next;
   logic             wrap_next;

   mod_next_state #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next (
      .count      (count),
      .up         (up),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .count_next (count_next),
      .wrap_next  (wrap_next),
      .tc         (tc)
   );

   // Count and wrap registers; clear forces zero immediately, regardless of clk.
   always_ff @(posedge clk or posedge clear) begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      if (clear) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three single digits (wrap, saturate, full
// 6-bit range) plus a two-digit decimal cascade, checked against an
// integer-arithmetic model of the counting rules.
module tb_mod_updown_counter;

   localparam int MODS [3] = '{10, 10, 64};
   localparam bit SATS [3] = '{1'b0, 1'b1, 1'b0};

   logic       clk = 1'b0;
   logic       clear;
   logic       en_v [3];
   logic       up_v [3];
   logic       ld_v [3];
   logic [5:0] lv_v [3];
   logic       c_en;

   wire [3:0] w_count, s_count;
   wire [5:0] f_count;
   wire [2:0] tc_o, wrap_o;
   wire [3:0] c0_count, c1_count;
   wire       c0_tc, c1_tc, c0_wrap, c1_wrap;

   int m_cnt [3];
   bit m_wrap [3];
   int c_val;
   int checks;
   int errors;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_w (
      .clk(clk), .clear(clear), .enable(en_v[0]), .up(up_v[0]), .load(ld_v[0]),
      .load_value(lv_v[0][3:0]), .count(w_count), .tc(tc_o[0]), .wrap(wrap_o[0]));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (
      .clk(clk), .clear(clear), .enable(en_v[1]), .up(up_v[1]), .load(ld_v[1]),
      .load_value(lv_v[1][3:0]), .count(s_count), .tc(tc_o[1]), .wrap(wrap_o[1]));

   mod_updown_counter #(.WIDTH(6), .MODULUS(64), .SATURATE(0)) u_f (
      .clk(clk), .clear(clear), .enable(en_v[2]), .up(up_v[2]), .load(ld_v[2]),
      .load_value(lv_v[2]), .count(f_count), .tc(tc_o[2]), .wrap(wrap_o[2]));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c0 (
      .clk(clk), .clear(clear), .enable(c_en), .up(1'b1), .load(1'b0),
      .load_value(4'd0), .count(c0_count), .tc(c0_tc), .wrap(c0_wrap));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c1 (
      .clk(clk), .clear(clear), .enable(c0_tc), .up(1'b1), .load(1'b0),
      .load_value(4'd0), .count(c1_count), .tc(c1_tc), .wrap(c1_wrap));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_cnt(input int i);
      case (i)
         0:       return 32'(w_count);
         1:       return 32'(s_count);
         default: return 32'(f_count);
      endcase
   endfunction

   task automatic set_all(input logic en, input logic up, input logic ld, input logic [5:0] lv);
      for (int i = 0; i < 3; i++) begin
         en_v[i] = en;
         up_v[i] = up;
         ld_v[i] = ld;
         lv_v[i] = lv;
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = 0;
         m_wrap[i] = 1'b0;
      end
      c_val = 0;
   endtask

   task automatic check_state(input string where);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_cnt%0d", where, i), obs_cnt(i), 32'(m_cnt[i]));
         check($sformatf("%s_wrap%0d", where, i), 32'(wrap_o[i]), 32'(m_wrap[i]));
      end
      check($sformatf("%s_c0", where), 32'(c0_count), 32'(c_val % 10));
      check($sformatf("%s_c1", where), 32'(c1_count), 32'(c_val / 10));
   endtask

   // One clock: check tc against current inputs, predict, clock, compare.
   task automatic step();
      int nc [3];
      bit nw [3];
      int cv_next;
      #1;
      for (int i = 0; i < 3; i++) begin
         int m = MODS[i];
         int c = m_cnt[i];
         int v = (i < 2) ? int'(lv_v[i][3:0]) : int'(lv_v[i]);
         int t;
         check($sformatf("tc%0d", i), 32'(tc_o[i]),
               32'(en_v[i] && (up_v[i] ? (c == m - 1) : (c == 0))));
         nc[i] = c;
         nw[i] = 1'b0;
         if (ld_v[i]) begin
            nc[i] = (v > m - 1) ? m - 1 : v;
         end else if (en_v[i]) begin
            t = c + (up_v[i] ? 1 : -1);
            if (t < 0 || t >= m) begin
               if (!SATS[i]) begin
                  nc[i] = (t + m) % m;
                  nw[i] = 1'b1;
               end
            end else begin
               nc[i] = t;
            end
         end
      end
      check("c0_tc", 32'(c0_tc), 32'(c_en && (c_val % 10 == 9)));
      check("c1_tc", 32'(c1_tc), 32'(c_en && (c_val == 99)));
      cv_next = c_en ? (c_val + 1) % 100 : c_val;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = nc[i];
         m_wrap[i] = nw[i];
      end
      c_val = cv_next;
      check_state("step");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear  = 1'b1;
      c_en   = 1'b0;
      set_all(1'b0, 1'b1, 1'b0, 6'd0);
      reset_model();
      #12;
      check_state("reset");
      clear = 1'b0;

      // Count up through the top bound: wrap, saturate, and plain binary.
      set_all(1'b1, 1'b1, 1'b0, 6'd0);
      repeat (11) step();

      // Clear mid-cycle at count 7, held across an edge with load pending.
      set_all(1'b0, 1'b1, 1'b1, 6'd7);
      step();
      set_all(1'b1, 1'b1, 1'b0, 6'd0);
      #3;
      clear = 1'b1;
      #1;
      reset_model();
      check_state("async_clear");
      set_all(1'b0, 1'b1, 1'b1, 6'd5);
      @(posedge clk);
      #1;
      check_state("clear_over_load");
      set_all(1'b1, 1'b1, 1'b0, 6'd0);
      #2;
      clear = 1'b0;
      step();

      // Count down from 2 past zero.
      set_all(1'b0, 1'b0, 1'b1, 6'd2);
      step();
      set_all(1'b1, 1'b0, 1'b0, 6'd0);
      repeat (4) step();

      // Load beats enable; over-range load clamps.
      set_all(1'b1, 1'b1, 1'b1, 6'd5);
      step();
      set_all(1'b1, 1'b1, 1'b1, 6'd12);
      step();

      // Direction flip at 4, then hold with enable low.
      set_all(1'b0, 1'b1, 1'b1, 6'd4);
      step();
      set_all(1'b1, 1'b1, 1'b0, 6'd0);
      step();
      set_all(1'b1, 1'b0, 1'b0, 6'd0);
      step();
      set_all(1'b0, 1'b0, 1'b0, 6'd0);
      repeat (3) step();

      // Full 6-bit range rollover 62, 63, 0, 1.
      set_all(1'b0, 1'b1, 1'b1, 6'd62);
      step();
      set_all(1'b1, 1'b1, 1'b0, 6'd0);
      repeat (3) step();

      // Randomized traffic; the cascade runs through 00..99 -> 00 meanwhile.
      c_en = 1'b1;
      repeat (400) begin
         for (int i = 0; i < 3; i++) begin
            en_v[i] = ($urandom_range(0, 3) != 0);
            up_v[i] = 1'($urandom_range(0, 1));
            ld_v[i] = ($urandom_range(0, 15) == 0);
            lv_v[i] = 6'($urandom_range(0, 63));
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous modulo-N up/down counter. Successor to the fixed 6-bit ripple counter. Adds the following, all under one clock:
- selectable count direction
- count enable
- synchronous parallel load
- programmable modulus
- optional saturation
- a terminal-count output for cascading

It sits wherever the design needs a timer, divider or event counter with a deterministic single-clock count.

## Interface
Parameters:
- WIDTH, 6, counter width in bits (≥1)
- MODULUS, 64, count range 0..MODULUS-1; legal 2 ≤ MODULUS ≤ 2**WIDTH
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  asynchronous, active-high reset
- enable  input  1  count enable; when 0, count holds (load still works)
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_value  input  WIDTH  value loaded when load=1
- count  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: enable & (up ? count==MODULUS-1 : count==0)
- wrap  output  1  registered one-cycle pulse: count wrapped on the previous edge

## Operation
- Reset (clear=1, any time, independent of clk): count=0, wrap=0. tc then follows its equation.
- Per-edge priority: clear > load > enable > hold.
- Load:
  - count ← load_value when load_value ≤ MODULUS-1.
  - count ← MODULUS-1 otherwise (clamp).
  - wrap ← 0.
- Count, enable=1, up=1:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1, SATURATE=0: count ← 0, wrap ← 1.
  - count == MODULUS-1, SATURATE=1: hold, wrap ← 0.
- Count, enable=1, up=0:
  - count > 0: count-1.
  - count == 0, SATURATE=0: count ← MODULUS-1, wrap ← 1.
  - count == 0, SATURATE=1: hold, wrap ← 0.
- Hold: enable=0 and load=0 leaves count unchanged; wrap ← 0.
- Arithmetic: all compare and next-state in WIDTH bits. MODULUS-1 is computed as a WIDTH-bit constant.
- MODULUS = 2**WIDTH must behave as natural binary rollover.
- Out-of-range states: count values ≥ MODULUS are reachable only through illegal parameters. Any such value is treated as "at top" and behaves like MODULUS-1.
- Direction change: `up` is sampled at the edge only; reversing mid-sequence takes effect on that edge with no lost or extra count.
- Cascading: tc of stage n drives enable of stage n+1 on the same clk, giving a synchronous multi-digit counter.

## Timing
- count and wrap change only on the rising clk edge, except the asynchronous clear.
- Latency: one cycle from load/enable to the new count.
- wrap is high for exactly the one cycle following the wrapping edge.
- tc is valid combinationally in the same cycle as count/enable/up.
- Clear deasserted mid-operation: the first count/load takes effect on the first rising edge after release. No partial update.
- load and enable both high: load wins; no count and no wrap that edge.
- clear asserted while load=1: count=0 immediately and stays 0 until clear falls.

## Structure
- Shared package `counter_pkg`:
  - direction constants (DIR_UP=1, DIR_DOWN=0)
  - mode constants (MODE_WRAP=0, MODE_SAT=1)
  - a function computing the clamped load value
- One natural sub-module, `mod_next_state`: combinational next-count, wrap and tc logic from (count, up, enable, load, load_value). The top holds only the registers and the async clear.
- The top level instantiates it once. Multi-digit cascades are built by instantiating `mod_updown_counter` repeatedly, not inside this block.

## Test plan
- Reset: WIDTH=4, MODULUS=10; clear=1 mid-count at count=7 → count=0 immediately, wrap=0. After release with up=1, enable=1, the first edge gives count=1.
- Up wrap: MODULUS=10, SATURATE=0, from 0 → sequence 0..9,0. wrap=1 only in the cycle after 9→0. tc=1 while count=9.
- Down wrap/saturate: from 2 with up=0 → 2,1,0,9 with wrap pulse (SATURATE=0). Same from 2 with SATURATE=1 → 2,1,0,0,0, wrap never 1, tc stays 1.
- Load: load_value=5 with enable=1 → count=5 next edge, no increment. load_value=12 with MODULUS=10 → count=9.
- Direction flip: counting up at 4, up→0 for one edge → 5 then 4. Then enable=0 for 3 cycles → 4 held, tc=0.
- Full range: WIDTH=6, MODULUS=64 → 63→0 rollover with wrap pulse, matching the 6-bit binary count. Two cascaded instances (tc→enable) with MODULUS=10 each count 00..99 → 00.
